// File: rtl/alu_panel_pkg.sv
// ---------------------------------------------------------------------------
// alu_panel_pkg
// Shared definitions for the ALU front-panel controller.
//   - panel_state_t : operation sequencer states (IDLE, ISSUE, CAPTURE)
//   - SEG_BLANK     : seven-segment code with every segment off
//   - SEG_ZERO      : seven-segment code for the digit "0"
//   - hex_to_seg()  : nibble to active-low seven-segment code, dp always off
// ---------------------------------------------------------------------------
package alu_panel_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2
    } panel_state_t;

    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] SEG_ZERO  = 8'hC0;

    // Bit 7 is the decimal point and stays 1 (off) in every code.
    function automatic logic [7:0] hex_to_seg(input logic [3:0] nibble);
        logic [7:0] seg;
        seg = SEG_BLANK;
        case (nibble)
            4'h0: seg = SEG_ZERO;
            4'h1: seg = 8'hF9;
            4'h2: seg = 8'hA4;
            4'h3: seg = 8'hB0;
            4'h4: seg = 8'h99;
            4'h5: seg = 8'h92;
            4'h6: seg = 8'h82;
            4'h7: seg = 8'hF8;
            4'h8: seg = 8'h80;
            4'h9: seg = 8'h90;
            4'hA: seg = 8'h88;
            4'hB: seg = 8'h83;
            4'hC: seg = 8'hC6;
            4'hD: seg = 8'hA1;
            4'hE: seg = 8'h86;
            4'hF: seg = 8'h8E;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/alu_panel_controller_if.sv
// ---------------------------------------------------------------------------
// alu_panel_controller_if
// Bus between the panel controller and the external combinational ALU.
//   ALUControl  [3:0]          mode to ALU           (master -> slave)
//   ALUInputA   [DataLength]   operand A             (master -> slave)
//   ALUInputB   [DataLength]   operand B             (master -> slave)
//   ALUCarryIn                 carry-in              (master -> slave)
//   ALUOutput   [DataLength]   result                (slave -> master)
//   ALUCarryOut                carry-out             (slave -> master)
// master = panel controller, slave = ALU.
// ---------------------------------------------------------------------------
interface alu_panel_controller_if #(
    parameter int DataLength = 8
);
    logic [3:0]            ALUControl;
    logic [DataLength-1:0] ALUInputA;
    logic [DataLength-1:0] ALUInputB;
    logic                  ALUCarryIn;
    logic [DataLength-1:0] ALUOutput;
    logic                  ALUCarryOut;

    modport master (
        output ALUControl,
        output ALUInputA,
        output ALUInputB,
        output ALUCarryIn,
        input  ALUOutput,
        input  ALUCarryOut
    );

    modport slave (
        input  ALUControl,
        input  ALUInputA,
        input  ALUInputB,
        input  ALUCarryIn,
        output ALUOutput,
        output ALUCarryOut
    );
endinterface

// File: rtl/key_debounce.sv
// ---------------------------------------------------------------------------
// key_debounce
// Synchronises a raw active-low push-button, debounces it and emits a
// one-cycle pulse on each released->pressed transition.
//   clk          system clock
//   reset        synchronous active-high reset (key returns to released)
//   key_n        raw button, active-low, asynchronous to clk
//   press_pulse  one-cycle high pulse when the debounced key becomes pressed
// Parameter DebounceCycles: consecutive synchronised samples differing from
// the current stable level that are needed before the level is accepted.
// ---------------------------------------------------------------------------
module key_debounce #(
    parameter int DebounceCycles = 500000
) (
    input  logic clk,
    input  logic reset,
    input  logic key_n,
    output logic press_pulse
);

    localparam int CountWidth = (DebounceCycles > 1) ? $clog2(DebounceCycles) : 1;
    localparam logic [CountWidth-1:0] CountLast = CountWidth'(DebounceCycles - 1);

    logic                  sync_meta;
    logic                  sync_q;
    logic                  stable_q;
    logic [CountWidth-1:0] count_q;

    // Two-flop synchroniser; resets to the released (high) level.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_meta <= 1'b1;
            sync_q    <= 1'b1;
        end else begin
            sync_meta <= key_n;
            sync_q    <= sync_meta;
        end
    end

    // Because the stable level is a single bit, every sample that differs
    // from it is the same value, so counting differing samples is the same
    // as counting identical ones. A sample equal to the stable level
    // restarts the run. The pulse is raised in the same cycle the stable
    // level flips to pressed (low).
    always_ff @(posedge clk) begin
        if (reset) begin
            stable_q    <= 1'b1;
            count_q     <= '0;
            press_pulse <= 1'b0;
        end else begin
            press_pulse <= 1'b0;
            if (sync_q == stable_q) begin
                count_q <= '0;
            end else if (count_q == CountLast) begin
                stable_q    <= sync_q;
                count_q     <= '0;
                press_pulse <= ~sync_q;
            end else begin
                count_q <= count_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_panel_controller.sv
// ---------------------------------------------------------------------------
// alu_panel_controller
// Registered front panel for an external combinational ALU: debounces the
// mode and execute buttons, steps the mode counter, sequences one ALU
// operation per execute press (optionally accumulating), captures the result
// and carry, and drives them onto seven-segment displays.
//   clk_50MHz         system clock
//   reset             synchronous active-high reset
//   keyMode_n         raw mode-step button, active-low
//   keyExec_n         raw execute button, active-low
//   switchSetA/B      operand switches
//   carryInSwitch     carry-in switch
//   accumulateSwitch  1 = operand A comes from the result register
//   alu_bus           master side of the ALU bus
//   modeLEDs          current mode counter
//   busyLED           high while an operation is in flight
//   HexResult         result digits, digit i in bits [8i+7:8i], digit 0 = LSN
//   HexCarry          carry digit
// ---------------------------------------------------------------------------
module alu_panel_controller
    import alu_panel_pkg::*;
#(
    parameter int DataLength     = 8,
    parameter int DebounceCycles = 500000,
    parameter int NumModes       = 16
) (
    input  logic                    clk_50MHz,
    input  logic                    reset,
    input  logic                    keyMode_n,
    input  logic                    keyExec_n,
    input  logic [DataLength-1:0]   switchSetA,
    input  logic [DataLength-1:0]   switchSetB,
    input  logic                    carryInSwitch,
    input  logic                    accumulateSwitch,
    alu_panel_controller_if.master  alu_bus,
    output logic [3:0]              modeLEDs,
    output logic                    busyLED,
    output logic [2*DataLength-1:0] HexResult,
    output logic [7:0]              HexCarry
);

    localparam int NumDigits = DataLength / 4;
    localparam logic [3:0] LastMode = 4'(NumModes - 1);

    panel_state_t          state_q;
    panel_state_t          state_d;
    logic                  mode_pulse;
    logic                  exec_pulse;
    logic [3:0]            mode_q;
    logic [3:0]            op_mode_q;
    logic [DataLength-1:0] result_q;
    logic                  carry_q;

    key_debounce #(.DebounceCycles(DebounceCycles)) u_mode_key (
        .clk         (clk_50MHz),
        .reset       (reset),
        .key_n       (keyMode_n),
        .press_pulse (mode_pulse)
    );

    key_debounce #(.DebounceCycles(DebounceCycles)) u_exec_key (
        .clk         (clk_50MHz),
        .reset       (reset),
        .key_n       (keyExec_n),
        .press_pulse (exec_pulse)
    );

    always_ff @(posedge clk_50MHz) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Exec pulses are only looked at in IDLE, so presses during an
    // operation are simply dropped.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (exec_pulse) state_d = ISSUE;
            ISSUE:   state_d = CAPTURE;
            CAPTURE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Mode pulses are honoured in every state.
    always_ff @(posedge clk_50MHz) begin
        if (reset) begin
            mode_q <= 4'd0;
        end else if (mode_pulse) begin
            mode_q <= (mode_q == LastMode) ? 4'd0 : mode_q + 4'd1;
        end
    end

    // The mode is snapshotted when the exec pulse is accepted, so a mode
    // press landing in that same cycle bumps the counter but not the
    // operation about to be issued.
    always_ff @(posedge clk_50MHz) begin
        if (reset) begin
            op_mode_q <= 4'd0;
        end else if (state_q == IDLE && exec_pulse) begin
            op_mode_q <= mode_q;
        end
    end

    // ALU operand registers load only in ISSUE and hold otherwise.
    always_ff @(posedge clk_50MHz) begin
        if (reset) begin
            alu_bus.ALUControl <= 4'd0;
            alu_bus.ALUInputA  <= '0;
            alu_bus.ALUInputB  <= '0;
            alu_bus.ALUCarryIn <= 1'b0;
        end else if (state_q == ISSUE) begin
            alu_bus.ALUControl <= op_mode_q;
            alu_bus.ALUInputA  <= accumulateSwitch ? result_q : switchSetA;
            alu_bus.ALUInputB  <= switchSetB;
            alu_bus.ALUCarryIn <= carryInSwitch;
        end
    end

    always_ff @(posedge clk_50MHz) begin
        if (reset) begin
            result_q <= '0;
            carry_q  <= 1'b0;
        end else if (state_q == CAPTURE) begin
            result_q <= alu_bus.ALUOutput;
            carry_q  <= alu_bus.ALUCarryOut;
        end
    end

    assign modeLEDs = mode_q;
    assign busyLED  = (state_q != IDLE);
    assign HexCarry = hex_to_seg({3'b000, carry_q});

    for (genvar i = 0; i < NumDigits; i++) begin : g_hex_digit
        assign HexResult[8*i +: 8] = hex_to_seg(result_q[4*i +: 4]);
    end

endmodule

// File: tb/tb_alu_panel_controller.sv
// ---------------------------------------------------------------------------
// tb_alu_panel_controller
// Directed bench for alu_panel_controller with a short debounce and an
// adder model standing in for the ALU (A + B + CarryIn, with carry-out).
// ---------------------------------------------------------------------------
module tb_alu_panel_controller;

    logic        clk_50MHz = 1'b0;
    logic        reset;
    logic        keyMode_n;
    logic        keyExec_n;
    logic [7:0]  switchSetA;
    logic [7:0]  switchSetB;
    logic        carryInSwitch;
    logic        accumulateSwitch;
    logic [3:0]  modeLEDs;
    logic        busyLED;
    logic [15:0] HexResult;
    logic [7:0]  HexCarry;

    int errorCount = 0;
    int checkCount = 0;

    alu_panel_controller_if #(.DataLength(8)) alu_bus ();

    // Behavioural ALU: 9-bit sum split into carry-out and result.
    assign {alu_bus.ALUCarryOut, alu_bus.ALUOutput} =
        {1'b0, alu_bus.ALUInputA} + {1'b0, alu_bus.ALUInputB} + {8'd0, alu_bus.ALUCarryIn};

    alu_panel_controller #(
        .DataLength     (8),
        .DebounceCycles (4),
        .NumModes       (16)
    ) dut (
        .clk_50MHz        (clk_50MHz),
        .reset            (reset),
        .keyMode_n        (keyMode_n),
        .keyExec_n        (keyExec_n),
        .switchSetA       (switchSetA),
        .switchSetB       (switchSetB),
        .carryInSwitch    (carryInSwitch),
        .accumulateSwitch (accumulateSwitch),
        .alu_bus          (alu_bus.master),
        .modeLEDs         (modeLEDs),
        .busyLED          (busyLED),
        .HexResult        (HexResult),
        .HexCarry         (HexCarry)
    );

    always #10 clk_50MHz = ~clk_50MHz;

    // Hard stop in case a wait somewhere never returns.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Waits (bounded) for busyLED, returning on the first negedge it is high.
    task automatic wait_busy(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk_50MHz);
            if (busyLED) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    task automatic press_mode();
        keyMode_n = 1'b0;
        repeat (10) @(negedge clk_50MHz);
        keyMode_n = 1'b1;
        repeat (10) @(negedge clk_50MHz);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        keyMode_n = 1'b1;
        keyExec_n = 1'b1;
        switchSetA = 8'h00;
        switchSetB = 8'h00;
        carryInSwitch = 1'b0;
        accumulateSwitch = 1'b0;
        repeat (2) @(posedge clk_50MHz);
        @(negedge clk_50MHz);
        checkCount++;
        if (modeLEDs !== 4'd0) begin errorCount++; $display("[TB] FAIL reset_mode: got %0h expected 0", modeLEDs); end
        checkCount++;
        if (busyLED !== 1'b0) begin errorCount++; $display("[TB] FAIL reset_busy: got %0b expected 0", busyLED); end
        checkCount++;
        if (HexResult !== 16'hC0C0) begin errorCount++; $display("[TB] FAIL reset_hex: got %h expected c0c0", HexResult); end
        checkCount++;
        if (HexCarry !== 8'hC0) begin errorCount++; $display("[TB] FAIL reset_carry: got %h expected c0", HexCarry); end
        checkCount++;
        if (alu_bus.ALUInputA !== 8'h00) begin errorCount++; $display("[TB] FAIL reset_alu_a: got %h expected 00", alu_bus.ALUInputA); end
        checkCount++;
        if (alu_bus.ALUControl !== 4'd0) begin errorCount++; $display("[TB] FAIL reset_alu_ctl: got %h expected 0", alu_bus.ALUControl); end
        reset = 1'b0;
        repeat (2) @(negedge clk_50MHz);
    endtask

    task automatic test_bounce();
        // Two-cycle runs never reach the four-sample threshold.
        for (int i = 0; i < 10; i++) begin
            keyMode_n = (i % 2 == 0) ? 1'b0 : 1'b1;
            repeat (2) @(negedge clk_50MHz);
        end
        checkCount++;
        if (modeLEDs !== 4'd0) begin errorCount++; $display("[TB] FAIL bounce_reject: got %0d expected 0", modeLEDs); end
        keyMode_n = 1'b0;
        repeat (10) @(negedge clk_50MHz);
        checkCount++;
        if (modeLEDs !== 4'd1) begin errorCount++; $display("[TB] FAIL bounce_press: got %0d expected 1", modeLEDs); end
        keyMode_n = 1'b1;
        repeat (10) @(negedge clk_50MHz);
        checkCount++;
        if (modeLEDs !== 4'd1) begin errorCount++; $display("[TB] FAIL bounce_release: got %0d expected 1", modeLEDs); end
    endtask

    task automatic test_sync_reset();
        reset = 1'b1;
        #1;
        checkCount++;
        if (modeLEDs !== 4'd1) begin errorCount++; $display("[TB] FAIL sync_reset_hold: got %0d expected 1", modeLEDs); end
        @(negedge clk_50MHz);
        checkCount++;
        if (modeLEDs !== 4'd0) begin errorCount++; $display("[TB] FAIL sync_reset_clear: got %0d expected 0", modeLEDs); end
        reset = 1'b0;
        @(negedge clk_50MHz);
    endtask

    task automatic test_mode_wrap();
        for (int i = 1; i <= 16; i++) begin
            press_mode();
            if (i == 15) begin
                checkCount++;
                if (modeLEDs !== 4'd15) begin errorCount++; $display("[TB] FAIL mode_top: got %0d expected 15", modeLEDs); end
            end
        end
        checkCount++;
        if (modeLEDs !== 4'd0) begin errorCount++; $display("[TB] FAIL mode_wrap: got %0d expected 0", modeLEDs); end
    endtask

    task automatic test_execute();
        bit seen;
        switchSetA = 8'h3C;
        switchSetB = 8'h0F;
        carryInSwitch = 1'b1;
        accumulateSwitch = 1'b0;
        keyExec_n = 1'b0;
        wait_busy(seen);
        checkCount++;
        if (!seen) begin errorCount++; $display("[TB] FAIL exec_busy: got 0 expected 1"); end
        @(negedge clk_50MHz);
        checkCount++;
        if (alu_bus.ALUInputA !== 8'h3C) begin errorCount++; $display("[TB] FAIL exec_a: got %h expected 3c", alu_bus.ALUInputA); end
        checkCount++;
        if (alu_bus.ALUInputB !== 8'h0F) begin errorCount++; $display("[TB] FAIL exec_b: got %h expected 0f", alu_bus.ALUInputB); end
        checkCount++;
        if (alu_bus.ALUCarryIn !== 1'b1) begin errorCount++; $display("[TB] FAIL exec_cin: got %b expected 1", alu_bus.ALUCarryIn); end
        checkCount++;
        if (HexResult !== 16'hC0C0) begin errorCount++; $display("[TB] FAIL exec_early: got %h expected c0c0", HexResult); end
        @(negedge clk_50MHz);
        checkCount++;
        if (HexResult !== 16'h99C6) begin errorCount++; $display("[TB] FAIL exec_hex: got %h expected 99c6", HexResult); end
        checkCount++;
        if (HexCarry !== 8'hC0) begin errorCount++; $display("[TB] FAIL exec_carry: got %h expected c0", HexCarry); end
        checkCount++;
        if (busyLED !== 1'b0) begin errorCount++; $display("[TB] FAIL exec_idle: got %b expected 0", busyLED); end
        keyExec_n = 1'b1;
        repeat (10) @(negedge clk_50MHz);
    endtask

    task automatic test_accumulate();
        bit seen;
        // Seed the result register with F0.
        switchSetA = 8'hF0;
        switchSetB = 8'h00;
        carryInSwitch = 1'b0;
        accumulateSwitch = 1'b0;
        keyExec_n = 1'b0;
        wait_busy(seen);
        repeat (2) @(negedge clk_50MHz);
        checkCount++;
        if (HexResult !== 16'h8EC0) begin errorCount++; $display("[TB] FAIL acc_seed: got %h expected 8ec0", HexResult); end
        keyExec_n = 1'b1;
        repeat (10) @(negedge clk_50MHz);
        // F0 + 20 = 1_10: result 10 with carry out.
        switchSetA = 8'h55;
        switchSetB = 8'h20;
        accumulateSwitch = 1'b1;
        keyExec_n = 1'b0;
        wait_busy(seen);
        checkCount++;
        if (!seen) begin errorCount++; $display("[TB] FAIL acc_busy: got 0 expected 1"); end
        @(negedge clk_50MHz);
        checkCount++;
        if (alu_bus.ALUInputA !== 8'hF0) begin errorCount++; $display("[TB] FAIL acc_a: got %h expected f0", alu_bus.ALUInputA); end
        @(negedge clk_50MHz);
        checkCount++;
        if (HexResult !== 16'hF9C0) begin errorCount++; $display("[TB] FAIL acc_hex: got %h expected f9c0", HexResult); end
        checkCount++;
        if (HexCarry !== 8'hF9) begin errorCount++; $display("[TB] FAIL acc_carry: got %h expected f9", HexCarry); end
        keyExec_n = 1'b1;
        repeat (10) @(negedge clk_50MHz);
    endtask

    task automatic test_collisions();
        bit seen;
        for (int i = 0; i < 5; i++) press_mode();
        checkCount++;
        if (modeLEDs !== 4'd5) begin errorCount++; $display("[TB] FAIL coll_setup: got %0d expected 5", modeLEDs); end
        // Result is 10; accumulate +1 should give exactly 11.
        switchSetB = 8'h01;
        carryInSwitch = 1'b0;
        accumulateSwitch = 1'b1;
        keyMode_n = 1'b0;
        keyExec_n = 1'b0;
        wait_busy(seen);
        checkCount++;
        if (!seen) begin errorCount++; $display("[TB] FAIL coll_busy: got 0 expected 1"); end
        // An extra exec pulse while the operation is in ISSUE.
        force dut.exec_pulse = 1'b1;
        @(negedge clk_50MHz);
        release dut.exec_pulse;
        checkCount++;
        if (alu_bus.ALUControl !== 4'd5) begin errorCount++; $display("[TB] FAIL coll_ctl: got %0d expected 5", alu_bus.ALUControl); end
        checkCount++;
        if (modeLEDs !== 4'd6) begin errorCount++; $display("[TB] FAIL coll_mode: got %0d expected 6", modeLEDs); end
        repeat (5) @(negedge clk_50MHz);
        checkCount++;
        if (HexResult !== 16'hF9F9) begin errorCount++; $display("[TB] FAIL coll_single: got %h expected f9f9", HexResult); end
        checkCount++;
        if (busyLED !== 1'b0) begin errorCount++; $display("[TB] FAIL coll_idle: got %b expected 0", busyLED); end
        keyMode_n = 1'b1;
        keyExec_n = 1'b1;
        repeat (10) @(negedge clk_50MHz);
    endtask

    task automatic test_reset_in_issue();
        bit seen;
        switchSetA = 8'h3C;
        switchSetB = 8'h0F;
        accumulateSwitch = 1'b0;
        keyExec_n = 1'b0;
        wait_busy(seen);
        checkCount++;
        if (!seen) begin errorCount++; $display("[TB] FAIL rst_issue_busy: got 0 expected 1"); end
        reset = 1'b1;
        keyExec_n = 1'b1;
        @(negedge clk_50MHz);
        checkCount++;
        if (busyLED !== 1'b0) begin errorCount++; $display("[TB] FAIL rst_issue_idle: got %b expected 0", busyLED); end
        checkCount++;
        if (alu_bus.ALUInputA !== 8'h00) begin errorCount++; $display("[TB] FAIL rst_issue_a: got %h expected 00", alu_bus.ALUInputA); end
        checkCount++;
        if (modeLEDs !== 4'd0) begin errorCount++; $display("[TB] FAIL rst_issue_mode: got %0d expected 0", modeLEDs); end
        @(negedge clk_50MHz);
        reset = 1'b0;
        repeat (5) @(negedge clk_50MHz);
        checkCount++;
        if (HexResult !== 16'hC0C0) begin errorCount++; $display("[TB] FAIL rst_issue_hex: got %h expected c0c0", HexResult); end
        checkCount++;
        if (HexCarry !== 8'hC0) begin errorCount++; $display("[TB] FAIL rst_issue_carry: got %h expected c0", HexCarry); end
    endtask

    initial begin
        $display("[TB] starting alu_panel_controller bench");
        test_reset();
        test_bounce();
        test_sync_reset();
        test_mode_wrap();
        test_execute();
        test_accumulate();
        test_collisions();
        test_reset_in_issue();
        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule

// File: doc/alu_panel_controller.md
Name: alu_panel_controller

Overview:
Parametrised, registered successor to the board-level ALU front panel. It debounces the two push-buttons and steps the ALU mode. On command it launches one ALU operation with registered operands, optionally in accumulator mode. It captures the result and carry, and drives the result as hexadecimal digits plus a carry digit on the seven-segment displays. It sits between the board I/O and an external combinational ALU instance.

Parameters:
DataLength, 8, ALU operand/result width in bits; must be a multiple of 4, range 4..16
NumDigits, DataLength/4, number of hex result displays (derived; not to be overridden)
DebounceCycles, 500000, consecutive stable synchronised samples needed to accept a key change (10 ms at 50 MHz)
NumModes, 16, number of ALU modes; mode counter wraps at NumModes-1

Ports:
clk_50MHz  in  1  system clock
reset  in  1  synchronous, active-high reset
keyMode_n  in  1  raw mode-step button, active-low, asynchronous to clock
keyExec_n  in  1  raw execute button, active-low, asynchronous to clock
switchSetA  in  DataLength  operand A switches
switchSetB  in  DataLength  operand B switches
carryInSwitch  in  1  carry-in switch
accumulateSwitch  in  1  1 = operand A taken from result register
ALUControl  out  4  registered mode to ALU
ALUInputA  out  DataLength  registered operand A to ALU
ALUInputB  out  DataLength  registered operand B to ALU
ALUCarryIn  out  1  registered carry-in to ALU
ALUOutput  in  DataLength  ALU result (combinational)
ALUCarryOut  in  1  ALU carry-out
modeLEDs  out  4  current mode counter
busyLED  out  1  high while not IDLE
HexResult  out  8*NumDigits  seven-segment digits, digit i in bits [8i+7:8i], digit 0 = least significant nibble
HexCarry  out  8  carry digit

Behaviour:
- Reset: all registers clear in the same clock cycle as reset is sampled high.
- Reset values: mode counter 0, ALU* outputs 0, result 0, carry 0, FSM IDLE, debouncers in the released state, busyLED 0.
- After reset every display shows "0" (8'hC0).
- Seven-segment encoding: active-low segments; bit 7 is the decimal point and is always 1 (off). Digit codes 0-F: C0 F9 A4 B0 99 92 82 F8 80 90 88 83 C6 A1 86 8E.
- Key path: 2-FF synchroniser, then debouncer.
  - The debouncer changes its stable state only after DebounceCycles consecutive identical synchronised samples that differ from the current stable state.
  - Any differing sample restarts the count.
  - A pulse is emitted for exactly 1 cycle on a released->pressed transition. Release emits nothing.
- Mode: each mode pulse increments the counter, wrapping from NumModes-1 to 0. modeLEDs shows the counter.
- FSM: IDLE -> ISSUE -> CAPTURE -> IDLE.
  - IDLE: an exec pulse moves to ISSUE.
  - ISSUE (1 cycle): load ALUControl with the mode counter, ALUInputB with switchSetB, and ALUCarryIn with carryInSwitch. Load ALUInputA with the result register if accumulateSwitch=1, otherwise with switchSetA.
  - CAPTURE (1 cycle): register ALUOutput into the result register and ALUCarryOut into the carry register, then return to IDLE.
  - Displays update the cycle after CAPTURE, i.e. 3 cycles after the exec pulse.
- ALU* outputs hold their values between operations.
- Exec pulses arriving outside IDLE are dropped.
- Mode pulses are always accepted. An operation in flight uses the mode latched at ISSUE.
- Exec and mode pulses in the same IDLE cycle: the operation uses the pre-increment mode; the counter increments in that same cycle.
- Reset mid-operation aborts to IDLE with all reset values; no capture occurs.
- Accumulator arithmetic is plain DataLength-bit feedback. Overflow behaviour belongs to the ALU; this block truncates nothing further.

Decomposition:
- Shared package alu_panel_pkg:
  - FSM state enum (IDLE, ISSUE, CAPTURE)
  - SEG_BLANK and SEG_ZERO constants
  - 16-entry hex-to-segment function
- One sub-module, key_debounce (synchroniser + debouncer + press pulse, parameter DebounceCycles), instantiated for each key.
- Hex decoding is done with the package function; there is no separate module.

Test Plan:
- Bench configuration: DebounceCycles=4, DataLength=8, behavioural ALU model returning A+B+CarryIn with the carry-out.
- Reset: assert reset 2 cycles -> modeLEDs=0, busyLED=0, HexResult=16'hC0C0, HexCarry=8'hC0; reset must not clear state until a clock edge.
- Bounce rejection: keyMode_n toggles low/high every 2 cycles for 20 cycles, then held low 10 cycles -> exactly one increment, modeLEDs 0->1; releasing produces no pulse.
- Mode wrap: 16 clean mode presses -> modeLEDs returns to 0.
- Execute: A=8'h3C, B=8'h0F, carryIn=1, one exec press -> ALUInputA=3C/B=0F in ISSUE; 3 cycles after the pulse HexResult shows "4C" (digit1=99, digit0=C6), carry digit C0.
- Accumulate with carry: result=8'hF0, accumulateSwitch=1, B=8'h20, carryIn=0, exec -> result 8'h10 shown as F9/C0, HexCarry=F9.
- Collisions: exec and mode pulses in the same cycle at mode 5 -> ALUControl=5, modeLEDs=6; a second exec during ISSUE is ignored (one capture only); reset asserted in ISSUE -> result stays 0.
